// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl
//   Iterative multiply/divide controller that sits in front of the HI/LO
//   register pair. MTHI/MTLO complete combinationally in IDLE. MULT/MULTU/DIV/DIVU
//   run 32 radix-2 steps on operand magnitudes, then write HI/LO in WRITE.
//
// Ports
//   Clk, Rst          clock, synchronous active-high reset
//   Start, Op, A, B   operation request (held until Accept), opcode, operands
//   ReadReq           mfhi/mflo in decode (drives Stall while busy)
//   HI_cur, LO_cur    current HI/LO register outputs
//   HI_next, LO_next  HI/LO register inputs (hold value unless writing)
//   Accept            Start taken this cycle
//   Busy              iterative operation in RUN or WRITE
//   Done              one-cycle result write pulse
//   Stall             pipeline hold request
//
// state | meaning
// IDLE  | waiting for Start; MT ops write here, HI/LO otherwise held
// RUN   | 32 shift-add / restoring-subtract steps, HI/LO held
// WRITE | sign-fixed result driven onto HI_next/LO_next, Done high
module hilo_muldiv_ctrl #(
  parameter logic [31:0] DIV_ZERO_LO = 32'hFFFFFFFF
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        ReadReq,
  input  logic [31:0] HI_cur,
  input  logic [31:0] LO_cur,
  output logic [31:0] HI_next,
  output logic [31:0] LO_next,
  output logic        Accept,
  output logic        Busy,
  output logic        Done,
  output logic        Stall
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WRITE} state_t;

  state_t      state_q;
  logic [5:0]  cnt_q;
  logic        busy_q, done_q;
  logic        is_div_q;
  logic        neg_q;       // sign of product or quotient
  logic        neg_rem_q;   // remainder takes the dividend's sign
  logic        bzero_q;
  logic [31:0] a_q;         // raw A, needed for the divide-by-zero HI value
  logic [31:0] m_q;         // multiplicand magnitude or divisor magnitude
  logic [31:0] hi_q, lo_q;

  logic        idle;
  logic        is_md, signed_op, a_neg, b_neg;
  logic [31:0] mag_a, mag_b;
  logic [32:0] sum;
  logic [32:0] shifted;
  logic        ge;
  logic [31:0] rem_sub;
  logic [31:0] step_hi, step_lo;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  assign idle      = (state_q == S_IDLE);
  assign Accept    = Start & idle & ~Rst;
  assign Busy      = busy_q & ~Rst;
  assign Done      = done_q & ~Rst;
  assign Stall     = (ReadReq | Start) & ~idle & ~Rst;

  assign is_md     = ~Op[2];
  assign signed_op = ~Op[0];
  assign a_neg     = signed_op & A[31];
  assign b_neg     = signed_op & B[31];
  assign mag_a     = a_neg ? -A : A;
  assign mag_b     = b_neg ? -B : B;

  // One iteration. Multiply shifts {hi,lo} right, adding m_q into the top half
  // when the multiplier LSB is set. Divide shifts the dividend out of lo into
  // the partial remainder; the remainder after a successful subtract is
  // always below m_q, so 32-bit wraparound subtraction is exact.
  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : 33'd0);
    shifted = {hi_q, lo_q[31]};
    ge      = (shifted >= {1'b0, m_q});
    rem_sub = shifted[31:0] - m_q;
    step_hi = sum[32:1];
    step_lo = {sum[0], lo_q[31:1]};
    if (is_div_q) begin
      step_hi = ge ? rem_sub : shifted[31:0];
      step_lo = {lo_q[30:0], ge};
    end
  end

  assign prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
  assign quo_fix  = neg_q ? -lo_q : lo_q;
  assign rem_fix  = neg_rem_q ? -hi_q : hi_q;

  always_comb begin
    HI_next = HI_cur;
    LO_next = LO_cur;
    if (Rst) begin
      HI_next = 32'd0;
      LO_next = 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Accept && Op == 3'b100) HI_next = A;
          if (Accept && Op == 3'b101) LO_next = A;
        end
        S_WRITE: begin
          if (!is_div_q) begin
            HI_next = prod_fix[63:32];
            LO_next = prod_fix[31:0];
          end else if (bzero_q) begin
            HI_next = a_q;
            LO_next = DIV_ZERO_LO;
          end else begin
            HI_next = rem_fix;
            LO_next = quo_fix;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Accept && is_md) begin
            is_div_q  <= Op[1];
            a_q       <= A;
            m_q       <= Op[1] ? mag_b : mag_a;
            lo_q      <= Op[1] ? mag_a : mag_b;
            hi_q      <= 32'd0;
            neg_q     <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            bzero_q   <= (B == 32'd0);
            cnt_q     <= 6'd0;
            busy_q    <= 1'b1;
            state_q   <= S_RUN;
          end
        end
        S_RUN: begin
          hi_q  <= step_hi;
          lo_q  <= step_lo;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            done_q  <= 1'b1;
            state_q <= S_WRITE;
          end
        end
        S_WRITE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
module tb_hilo_muldiv_ctrl;

  logic        Clk = 1'b0;
  logic        Rst, Start, ReadReq;
  logic [2:0]  Op;
  logic [31:0] A, B, HI_cur, LO_cur;
  logic [31:0] HI_next, LO_next;
  logic        Accept, Busy, Done, Stall;

  always #5 Clk = ~Clk;

  hilo_muldiv_ctrl #(.DIV_ZERO_LO(32'hFFFFFFFF)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B),
    .ReadReq(ReadReq), .HI_cur(HI_cur), .LO_cur(LO_cur),
    .HI_next(HI_next), .LO_next(LO_next), .Accept(Accept),
    .Busy(Busy), .Done(Done), .Stall(Stall)
  );

  // HI/LO register pair fed by the controller
  always @(posedge Clk) begin
    HI_cur <= HI_next;
    LO_cur <= LO_next;
  end

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   acc_cyc  = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: result writes appear on Done (mul/div) or on Accept (MTHI/MTLO)
  always @(negedge Clk) begin
    exp_t e;
    if (Accept && !Op[2]) acc_cyc = cyc;
    if (Done || (Accept && Op[2:1] == 2'b10)) begin
      chk("sb_has_expect", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk({e.name, "_hi_next"}, HI_next, e.hi);
        chk({e.name, "_lo_next"}, LO_next, e.lo);
        if (Done) chk({e.name, "_latency"}, 32'(cyc - acc_cyc), 32'd33);
      end
    end
  end

  // Entered and left just after a rising edge.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input string nm);
    exp_t e;
    int   w, bc;
    e.hi = eh; e.lo = el; e.name = nm;
    if (op[2:1] != 2'b11) sb_q.push_back(e);
    Start = 1'b1; Op = op; A = a; B = b;
    w = 0;
    while (1) begin
      @(negedge Clk);
      if (Accept) break;
      w++;
      if (w > 50) break;
    end
    chk({nm, "_accept"}, 32'(Accept), 32'd1);
    @(posedge Clk); #1;
    Start = 1'b0; A = $urandom; B = $urandom;
    if (!op[2]) begin
      bc = 0;
      while (1) begin
        @(negedge Clk);
        if (!Busy) break;
        bc++;
        if (bc > 100) break;
      end
      chk({nm, "_busy_cycles"}, 32'(bc), 32'd33);
      chk({nm, "_hi_reg"}, HI_cur, eh);
      chk({nm, "_lo_reg"}, LO_cur, el);
      @(posedge Clk); #1;
    end else begin
      chk({nm, "_hi_reg"}, HI_cur, eh);
      chk({nm, "_lo_reg"}, LO_cur, el);
      chk({nm, "_busy"}, 32'(Busy), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    int   bc, bad, dn;

    Rst = 1'b1; Start = 1'b1; Op = 3'b000; A = 32'd5; B = 32'd5; ReadReq = 1'b1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("rst_accept", 32'(Accept), 32'd0);
    chk("rst_busy",   32'(Busy),   32'd0);
    chk("rst_done",   32'(Done),   32'd0);
    chk("rst_stall",  32'(Stall),  32'd0);
    chk("rst_hi_next", HI_next, 32'd0);
    chk("rst_lo_next", LO_next, 32'd0);
    @(posedge Clk); #1;
    Rst = 1'b0; Start = 1'b0; ReadReq = 1'b0;
    chk("rst_hi_reg", HI_cur, 32'd0);
    chk("rst_lo_reg", LO_cur, 32'd0);

    run_op(3'b000, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, "mult_m3x7");
    run_op(3'b010, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7_2");
    run_op(3'b011, 32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF, "divu_max_16");
    run_op(3'b011, 32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF, "divu_by_zero");
    run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max");
    run_op(3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_min_sq");
    run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_min_m1");
    run_op(3'b010, 32'd100,      32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, "div_100_m7");
    run_op(3'b110, 32'h1234,     32'h5678,     32'h00000002, 32'hFFFFFFF2, "nop");
    run_op(3'b101, 32'h0BADBEEF, 32'd0,        32'h00000002, 32'h0BADBEEF, "mtlo");
    run_op(3'b010, 32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF, "div_by_zero");

    // MULTU with ReadReq and a held MTHI behind it
    e.hi = 32'h1; e.lo = 32'h0; e.name = "stl_multu"; sb_q.push_back(e);
    Start = 1'b1; Op = 3'b001; A = 32'h00010000; B = 32'h00010000; ReadReq = 1'b0;
    @(negedge Clk);
    chk("stl_multu_accept", 32'(Accept), 32'd1);
    @(posedge Clk); #1;
    Op = 3'b100; A = 32'hCAFEF00D; B = $urandom; ReadReq = 1'b1;
    e.hi = 32'hCAFEF00D; e.lo = 32'h0; e.name = "stl_mthi"; sb_q.push_back(e);
    bc = 0; bad = 0;
    while (1) begin
      @(negedge Clk);
      if (!Busy) break;
      bc++;
      if (!Stall || Accept) bad++;
      if (bc > 100) break;
    end
    chk("stl_busy_cycles", 32'(bc), 32'd33);
    chk("stl_stall_bad_cycles", 32'(bad), 32'd0);
    chk("stl_idle_stall", 32'(Stall), 32'd0);
    chk("stl_mthi_accept", 32'(Accept), 32'd1);
    chk("stl_multu_hi_reg", HI_cur, 32'h1);
    chk("stl_multu_lo_reg", LO_cur, 32'h0);
    @(posedge Clk); #1;
    Start = 1'b0; ReadReq = 1'b0;
    chk("stl_mthi_hi_reg", HI_cur, 32'hCAFEF00D);
    chk("stl_mthi_lo_reg", LO_cur, 32'h0);

    // Reset abort at iteration counter 10
    Start = 1'b1; Op = 3'b000; A = 32'd3; B = 32'd3;
    @(negedge Clk);
    chk("abort_accept", 32'(Accept), 32'd1);
    @(posedge Clk); #1;
    Start = 1'b0; ReadReq = 1'b1;
    repeat (10) @(posedge Clk);
    #1;
    Rst = 1'b1;
    #1;
    chk("abort_hi_next", HI_next, 32'd0);
    chk("abort_lo_next", LO_next, 32'd0);
    chk("abort_busy_in_rst", 32'(Busy), 32'd0);
    chk("abort_stall_in_rst", 32'(Stall), 32'd0);
    @(posedge Clk); #1;
    Rst = 1'b0; ReadReq = 1'b0;
    chk("abort_hi_reg", HI_cur, 32'd0);
    chk("abort_lo_reg", LO_cur, 32'd0);
    chk("abort_busy", 32'(Busy), 32'd0);
    dn = 0;
    repeat (40) begin
      @(negedge Clk);
      if (Done || Busy) dn++;
    end
    chk("abort_no_activity", 32'(dn), 32'd0);
    @(posedge Clk); #1;
    run_op(3'b000, 32'hFFFFFFFE, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF6, "mult_after_abort");

    repeat (3) @(posedge Clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_ctrl.md
HILO_MULDIV_CTRL -- requirements
Module: hilo_muldiv_ctrl

Interface
REQ-001 The block SHALL have one parameter: DIV_ZERO_LO, default 32'hFFFFFFFF, the LO value written on divide-by-zero.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 The block SHALL have these ports, clock and reset first:
- Clk  in  1  clock.
- Rst  in  1  synchronous active-high reset.
- Start  in  1  operation request, held by the requester until accepted.
- Op  in  3  operation code: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op.
- A  in  32  rs operand (dividend, multiplicand, or MT data).
- B  in  32  rt operand (divisor, multiplier).
- ReadReq  in  1  mfhi/mflo present in decode.
- HI_cur  in  32  current HI register output.
- LO_cur  in  32  current LO register output.
- HI_next  out  32  HI register input.
- LO_next  out  32  LO register input.
- Accept  out  1  Start taken this cycle.
- Busy  out  1  iterative operation in flight.
- Done  out  1  one-cycle result write pulse.
- Stall  out  1  pipeline hold request.

Function
REQ-004 The FSM SHALL have three states: IDLE, RUN and WRITE.
REQ-005 Accept SHALL equal Start & (state==IDLE) & ~Rst; Start outside IDLE SHALL be ignored.
REQ-006 In IDLE, HI_next and LO_next SHALL equal HI_cur and LO_cur, which holds the registers.
REQ-007 For MTHI or MTLO on Accept, HI_next or LO_next respectively SHALL equal A combinationally in that same cycle; the other register SHALL be held; the state SHALL remain IDLE.
REQ-008 For a 11x no-op on Accept, there SHALL be no register change and no state change.
REQ-009 For MULT, MULTU, DIV or DIVU on Accept, the block SHALL capture A, B and Op, set an iteration counter to 0, and go to RUN.
REQ-010 In RUN, the block SHALL perform one radix-2 shift-add or restoring-subtract step per edge for exactly 32 edges, then go to WRITE.
REQ-011 Signed ops SHALL operate on magnitudes and apply the sign fix in WRITE.
REQ-012 In WRITE, the block SHALL drive HI_next and LO_next with the result, assert Done, and return to IDLE on the next edge.
REQ-013 Latency: Accept at edge E0 -> Done high in the cycle after E32 -> HI_cur and LO_cur updated after E33.
REQ-014 Busy SHALL be 1 in RUN and WRITE; HI_next and LO_next SHALL hold HI_cur and LO_cur in RUN.
REQ-015 Multiply results: MULT SHALL produce the 64-bit two's-complement product {HI,LO}; MULTU SHALL produce the 64-bit unsigned product.
REQ-016 Divide results: LO = quotient and HI = remainder; DIV SHALL truncate toward zero with the remainder taking the dividend's sign; DIVU SHALL be unsigned.
REQ-017 Divide by zero: the block SHALL still take the full latency, with LO = DIV_ZERO_LO and HI = A as captured.
REQ-018 DIV of 0x80000000 by 0xFFFFFFFF SHALL give LO = 0x80000000 and HI = 0.
REQ-019 Stall SHALL equal (ReadReq | Start) & (state != IDLE); it SHALL be deasserted in IDLE.
REQ-020 There SHALL be no mfhi hazard in the Done cycle, because Stall is still asserted then.
REQ-021 Operands SHALL be used only as captured; A and B changing during RUN SHALL have no effect.

Reset
REQ-022 While Rst=1, the block SHALL set state = IDLE, counter = 0, and hold Busy, Done, Accept and Stall at 0.
REQ-023 While Rst=1, HI_next and LO_next SHALL be 0 so the HI/LO registers clear on the same edge.
REQ-024 Rst asserted in RUN or WRITE SHALL abort the operation with no result write; operation SHALL be IDLE from the first edge after Rst deasserts.

Verification
REQ-025 The bench SHALL cover: MULT A=0xFFFFFFFD, B=7 -> Done 33 cycles after Accept -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-026 The bench SHALL cover: DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; then DIVU A=0xFFFFFFFF, B=0x10 -> LO=0x0FFFFFFF, HI=0xF.
REQ-027 The bench SHALL cover: DIVU A=0x12345678, B=0 -> LO=0xFFFFFFFF, HI=0x12345678, Busy high for exactly 33 cycles.
REQ-028 The bench SHALL cover: ReadReq=1 and a second Start (MTHI) held during MULTU -> Stall=1 and Accept=0 until IDLE; MTHI A=0xCAFEF00D then accepted, HI=0xCAFEF00D one edge later, LO unchanged.
REQ-029 The bench SHALL cover: Rst=1 at RUN counter 10 -> Busy=0 next cycle, HI and LO = 0, no Done pulse; a new MULT then completes correctly.
REQ-030 The bench SHALL cover: MULT A=0x80000000, B=0x80000000 -> HI=0x40000000, LO=0; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
